// File: rtl/apb3_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb3_master_arbiter
//   Round-robin arbiter plus APB3 master sequencer. NREQ requesters share one
//   APB3 bus; one transfer runs at a time (IDLE -> SETUP -> ACCESS -> DONE)
//   and the owner receives a one-cycle req_ack with read data and error.
//
// Optional feature macro: YAUART_APB_ARB_TIMEOUT_EN
//   defined   : ACCESS is abandoned after TIMEOUT cycles of PREADY=0 and
//               completes with rsp_err=1, rsp_rdata=0.
//   undefined : ACCESS waits for PREADY indefinitely.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   req_valid/write       per-requester request and direction
//   req_addr/req_wdata    flattened per-requester payload (slice i = req i)
//   req_ack               one-hot completion pulse
//   rsp_rdata, rsp_err    completion data/status, held until next completion
//   PADDR..PENABLE        APB3 master outputs
//   PRDATA/PREADY/PSLVERR APB3 slave responses
// ---------------------------------------------------------------------------
module apb3_master_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned APB3_AW = 32,
   parameter int unsigned APB3_DW = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_write,
   input  logic [NREQ*APB3_AW-1:0] req_addr,
   input  logic [NREQ*APB3_DW-1:0] req_wdata,
   output logic [NREQ-1:0]         req_ack,
   output logic [APB3_DW-1:0]      rsp_rdata,
   output logic                    rsp_err,
   output logic [APB3_AW-1:0]      PADDR,
   output logic [APB3_DW-1:0]      PWDATA,
   output logic                    PWRITE,
   output logic                    PSEL,
   output logic                    PENABLE,
   input  logic [APB3_DW-1:0]      PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   // Elaboration-time parameter sanity check
   if (NREQ < 2 || TIMEOUT < 1) begin : g_param_chk
      $error("apb3_master_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic [PW-1:0]       r_rr_ptr,  w_rr_ptr_nxt;
   logic [PW-1:0]       r_grant,   w_grant_nxt;
   logic [NREQ-1:0]     r_ack,     w_ack_nxt;
   logic [APB3_DW-1:0]  r_rdata,   w_rdata_nxt;
   logic                r_err,     w_err_nxt;
   logic [APB3_AW-1:0]  r_paddr,   w_paddr_nxt;
   logic [APB3_DW-1:0]  r_pwdata,  w_pwdata_nxt;
   logic                r_pwrite,  w_pwrite_nxt;
   logic                r_psel,    w_psel_nxt;
   logic                r_penable, w_penable_nxt;
`ifdef YAUART_APB_ARB_TIMEOUT_EN
   logic [TO_W-1:0]     r_to_cnt,  w_to_cnt_nxt;
`endif

   logic                w_any;
   logic [PW-1:0]       w_gnt;
   logic [PW-1:0]       w_cand;
   logic [APB3_AW-1:0]  w_sel_addr;
   logic [APB3_DW-1:0]  w_sel_wdata;
   logic                w_sel_write;

   // Round-robin search: first pending requester at or above rr_ptr, wrapping
   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      w_cand = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         w_cand = PW'((int'(r_rr_ptr) + k) % int'(NREQ));
         if (!w_any && req_valid[w_cand]) begin
            w_any = 1'b1;
            w_gnt = w_cand;
         end
      end
   end

   // Payload of the requester being granted this cycle
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_write = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_gnt == PW'(i)) begin
            w_sel_addr  = req_addr[i*APB3_AW +: APB3_AW];
            w_sel_wdata = req_wdata[i*APB3_DW +: APB3_DW];
            w_sel_write = req_write[i];
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_grant_nxt   = r_grant;
      w_ack_nxt     = '0;
      w_rdata_nxt   = r_rdata;
      w_err_nxt     = r_err;
      w_paddr_nxt   = r_paddr;
      w_pwdata_nxt  = r_pwdata;
      w_pwrite_nxt  = r_pwrite;
      w_psel_nxt    = r_psel;
      w_penable_nxt = r_penable;
`ifdef YAUART_APB_ARB_TIMEOUT_EN
      w_to_cnt_nxt  = r_to_cnt;
`endif

      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt   = S_SETUP;
               w_grant_nxt   = w_gnt;
               w_rr_ptr_nxt  = PW'((int'(w_gnt) + 1) % int'(NREQ));
               w_paddr_nxt   = w_sel_addr;
               w_pwdata_nxt  = w_sel_wdata;
               w_pwrite_nxt  = w_sel_write;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
`ifdef YAUART_APB_ARB_TIMEOUT_EN
               w_to_cnt_nxt  = '0;
`endif
            end
         end

         S_SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = S_ACCESS;
         end

         S_ACCESS: begin
            if (PREADY) begin
               w_rdata_nxt   = r_pwrite ? '0 : PRDATA;
               w_err_nxt     = PSLVERR;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_ack_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
               w_state_nxt   = S_DONE;
            end
`ifdef YAUART_APB_ARB_TIMEOUT_EN
            // Last permitted wait cycle: terminate as an errored completion
            else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
               w_rdata_nxt   = '0;
               w_err_nxt     = 1'b1;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_ack_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
               w_state_nxt   = S_DONE;
            end else begin
               w_to_cnt_nxt  = r_to_cnt + TO_W'(1);
            end
`endif
         end

         // Ack pulse is visible here; no arbitration so requesters can drop
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_ack     <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pwrite  <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
`ifdef YAUART_APB_ARB_TIMEOUT_EN
         r_to_cnt  <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_grant   <= w_grant_nxt;
         r_ack     <= w_ack_nxt;
         r_rdata   <= w_rdata_nxt;
         r_err     <= w_err_nxt;
         r_paddr   <= w_paddr_nxt;
         r_pwdata  <= w_pwdata_nxt;
         r_pwrite  <= w_pwrite_nxt;
         r_psel    <= w_psel_nxt;
         r_penable <= w_penable_nxt;
`ifdef YAUART_APB_ARB_TIMEOUT_EN
         r_to_cnt  <= w_to_cnt_nxt;
`endif
      end
   end

   assign req_ack   = r_ack;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PWRITE    = r_pwrite;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;

endmodule
